mem_stage_bus: RTL

- MEM pipeline stage of the 5-stage core, between the EX/MEM and MEM/WB registers.
- Performs the actual data-memory access over a req/ack bus:
  - byte/half/word loads and stores;
  - little-endian lane selection;
  - sign/zero extension;
  - misalignment detection;
  - bus timeout.
- Non-memory ops pass through combinationally with zero latency.
- Raises stallreq_o to freeze upstream stages while an access is in flight.

---
 rtl/mem_stage_bus.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_bus.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_bus
// Brief    : MEM pipeline stage. Performs data-memory loads/stores over a
//            req/ack bus with lane steering, load extension, misalignment
//            detection and bus timeout; non-memory ops pass straight through.
// Revision : 1.0  initial release
// ============================================================================
module mem_stage_bus #(
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            memop_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           store_data_i,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [3:0]            bus_sel_o,
  output logic [31:0]           bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [31:0]           bus_rdata_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stallreq_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [3:0] c_OP_LB  = 4'd1;
  localparam logic [3:0] c_OP_LBU = 4'd2;
  localparam logic [3:0] c_OP_LH  = 4'd3;
  localparam logic [3:0] c_OP_LHU = 4'd4;
  localparam logic [3:0] c_OP_LW  = 4'd5;
  localparam logic [3:0] c_OP_SB  = 4'd6;
  localparam logic [3:0] c_OP_SH  = 4'd7;
  localparam logic [3:0] c_OP_SW  = 4'd8;

  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_err;
  logic                r_load;
  logic [3:0]          r_memop;
  logic [1:0]          r_off;
  logic [31:0]         r_rdata;
  logic                r_bus_req;
  logic                r_bus_we;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [3:0]          r_bus_sel;
  logic [31:0]         r_bus_wdata;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic [1:0]  w_size;
  logic        w_misaligned;
  logic        w_idle;
  logic        w_misalign;
  logic        w_start;
  logic [3:0]  w_sel;
  logic [31:0] w_lane_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_fmt;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_size     = c_SZ_WORD;
    case (memop_i)
      c_OP_LB, c_OP_LBU: begin w_is_load  = 1'b1; w_size = c_SZ_BYTE; end
      c_OP_LH, c_OP_LHU: begin w_is_load  = 1'b1; w_size = c_SZ_HALF; end
      c_OP_LW:           begin w_is_load  = 1'b1; w_size = c_SZ_WORD; end
      c_OP_SB:           begin w_is_store = 1'b1; w_size = c_SZ_BYTE; end
      c_OP_SH:           begin w_is_store = 1'b1; w_size = c_SZ_HALF; end
      c_OP_SW:           begin w_is_store = 1'b1; w_size = c_SZ_WORD; end
      default:           ;
    endcase
  end

  assign w_is_mem     = w_is_load | w_is_store;
  assign w_misaligned = ((w_size == c_SZ_HALF) & mem_addr_i[0]) |
                        ((w_size == c_SZ_WORD) & (|mem_addr_i[1:0]));
  assign w_idle       = (r_state == ST_IDLE);
  assign w_misalign   = w_idle & valid_i & w_is_mem & w_misaligned;
  assign w_start      = w_idle & valid_i & w_is_mem & ~w_misaligned;

  // Lane enables and store data replicated across all lanes.
  always_comb begin
    w_sel       = 4'b1111;
    w_lane_data = store_data_i;
    case (w_size)
      c_SZ_BYTE: begin
        w_sel       = 4'b0001 << mem_addr_i[1:0];
        w_lane_data = {4{store_data_i[7:0]}};
      end
      c_SZ_HALF: begin
        w_sel       = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_off)
      2'd0:    w_byte = bus_rdata_i[7:0];
      2'd1:    w_byte = bus_rdata_i[15:8];
      2'd2:    w_byte = bus_rdata_i[23:16];
      default: w_byte = bus_rdata_i[31:24];
    endcase
    w_half = r_off[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (r_memop)
      c_OP_LB:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
      c_OP_LBU: w_load_fmt = {24'd0, w_byte};
      c_OP_LH:  w_load_fmt = {{16{w_half[15]}}, w_half};
      c_OP_LHU: w_load_fmt = {16'd0, w_half};
      default:  w_load_fmt = bus_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_load      <= 1'b0;
      r_memop     <= '0;
      r_off       <= '0;
      r_rdata     <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_sel   <= '0;
      r_bus_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_BUSY;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_load      <= w_is_load;
            r_memop     <= memop_i;
            r_off       <= mem_addr_i[1:0];
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_is_store;
            r_bus_addr  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            r_bus_sel   <= w_sel;
            r_bus_wdata <= w_is_store ? w_lane_data : 32'd0;
          end
        end
        ST_BUSY: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (bus_ack_i) begin
            r_state     <= ST_DONE;
            r_rdata     <= w_load_fmt;
            r_err       <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= '0;
            r_bus_wdata <= '0;
          end else if ((TIMEOUT != 0) && (r_cnt == c_CNT_LAST)) begin
            r_state     <= ST_DONE;
            r_err       <= 1'b1;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= '0;
            r_bus_wdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Reset forces every output low, even before the first clock edge.
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stallreq_o  = 1'b0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_sel_o   = '0;
    bus_wdata_o = '0;
    if (!rst) begin
      wd_o        = wd_i;
      wdata_o     = wdata_i;
      stallreq_o  = w_start | (r_state == ST_BUSY);
      misalign_o  = w_misalign;
      bus_err_o   = (r_state == ST_DONE) & r_err;
      bus_req_o   = r_bus_req;
      bus_we_o    = r_bus_we;
      bus_addr_o  = r_bus_addr;
      bus_sel_o   = r_bus_sel;
      bus_wdata_o = r_bus_wdata;
      case (r_state)
        ST_IDLE: wreg_o = valid_i & wreg_i & ~w_is_mem;
        ST_DONE: begin
          wreg_o = wreg_i & ~r_err;
          if (r_load) wdata_o = r_rdata;
        end
        default: wreg_o = 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire
